// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU memory port and mem_responder.
// master = requester side, slave = responder side.
interface mem_responder_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word memory responder: valid/ready request, WAIT_CYCLES wait states, one-cycle response.
// Define MEMRESP_ALIGN_CHECK_EN to flag req_addr[1:0] != 0 as an access error.
module mem_responder #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t                state_reg;
  logic [3:0]            cnt_reg;
  logic                  we_reg;
  logic [AW-1:0]         addr_reg;
  logic [DW-1:0]         wdata_reg;
  logic                  rsp_valid_reg;
  logic                  rsp_err_reg;
  logic                  rdata_sel_reg;
  logic [DW-1:0]         rd_word_reg;
  logic [DW-1:0]         mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  addr_err;

  assign idx = addr_reg[DEPTH_LOG2+1:2];

`ifdef MEMRESP_ALIGN_CHECK_EN
  assign addr_err = (addr_reg[AW-1:DEPTH_LOG2+2] != '0) || (addr_reg[1:0] != 2'b00);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_reg[1:0];
  assign addr_err = (addr_reg[AW-1:DEPTH_LOG2+2] != '0);
`endif

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  // The raw array word only reaches the output for a good read; writes/errors return zero.
  assign bus.rsp_rdata = rdata_sel_reg ? rd_word_reg : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rdata_sel_reg <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            we_reg    <= bus.req_we;
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
            cnt_reg   <= WAIT_INIT;
            if (WAIT_CYCLES == 0) state_reg <= ACCESS;
            else                  state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) state_reg <= ACCESS;
          else                 cnt_reg   <= cnt_reg - 4'd1;
        end
        ACCESS: begin
          state_reg     <= RESP;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= addr_err;
          rdata_sel_reg <= !we_reg && !addr_err;
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Array port kept free of reset so it maps onto block RAM; rd_word_reg is the registered read.
  always_ff @(posedge clk) begin
    if (state_reg == ACCESS) begin
      if (we_reg && !addr_err) mem[idx] <= wdata_reg;
      rd_word_reg <= mem[idx];
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, reset abort, WAIT_CYCLES=0 back-to-back, random vs model.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam int WAITS = 2;

  always #5 clk = ~clk;

  mem_responder_if #(.AW(32), .DW(32)) bus ();
  mem_responder_if #(.AW(32), .DW(32)) bus0 ();

  mem_responder #(.AW(32), .DW(32), .DEPTH_LOG2(10), .WAIT_CYCLES(WAITS)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  mem_responder #(.AW(32), .DW(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  // Reference model: plain word array plus "has been written" flags.
  logic [31:0] mm [1024];
  bit          mv [1024];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[14];

  logic [31:0] b_addr [4];
  logic [31:0] b_wd   [4];
  logic        b_we   [4];
  logic [31:0] b_exp  [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic er, output bit known);
    int unsigned w;
    bit bad;
    w = (addr / 4) % 1024;
    bad = (addr >= 32'h1000);
`ifdef MEMRESP_ALIGN_CHECK_EN
    if (addr % 4 != 0) bad = 1;
`endif
    er = bad;
    rd = 32'h0;
    known = 1;
    if (!bad) begin
      if (we) begin
        mm[w] = wdata;
        mv[w] = 1;
      end else begin
        rd = mm[w];
        known = mv[w];
      end
    end
  endfunction

  task automatic txn(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    int n, lat, busy_n;
    rdata = 32'h0;
    err = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s accept timeout: req_ready stayed 0", tag);
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Inputs are scrambled after accept to prove the request was latched.
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    chk({tag, " ready_after_accept"}, 32'(bus.req_ready), 32'd0);
    lat = 1;
    busy_n = 0;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL %s response timeout: rsp_valid=0 after %0d cycles, required 1", tag, lat);
      return;
    end
    if (bus.busy) busy_n++;
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    chk({tag, " latency"}, 32'(lat), 32'(WAITS + 2));
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(WAITS + 2));
    @(negedge clk);
    chk({tag, " rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " ready_idle"}, 32'(bus.req_ready), 32'd1);
    chk({tag, " rdata_hold"}, bus.rsp_rdata, rdata);
    $display("txn %s we=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             tag, we, addr, wdata, rdata, err, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, mrd;
    logic er, mer;
    bit known;
    int acc_cyc [4];
    int last_rsp, na, nr;
    bit pend;
    int seen;

    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    for (int i = 0; i < 1024; i++) mv[i] = 0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_1000, 32'h0000_0001, 32'h0, 1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 32'h8000_0020, 32'h0,         32'h0, 1'b1};
`ifdef MEMRESP_ALIGN_CHECK_EN
    vecs[9]  = '{1'b1, 32'h0000_0022, 32'h6666_6666, 32'h0, 1'b1};
    vecs[10] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1111_1111, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0013, 32'h0,         32'h0, 1'b1};
    vecs[13] = '{1'b0, 32'h0000_1003, 32'h0,         32'h0, 1'b1};
`else
    vecs[9]  = '{1'b1, 32'h0000_0022, 32'h6666_6666, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0020, 32'h0,         32'h6666_6666, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_1003, 32'h0,         32'h0, 1'b1};
`endif

    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      model(vecs[i].we, vecs[i].addr, vecs[i].wdata, mrd, mer, known);
    end

    // Reset during WAIT abandons the write to 0x20.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h55;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort busy_in_wait", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort async busy", 32'(bus.busy), 32'd0);
    chk("abort async ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("abort no_response", 32'(seen), 32'd0);
    $display("txn abort we=1 addr=0x00000020 wdata=0x00000055 -> reset in WAIT, responses seen=%0d", seen);
    model(1'b0, 32'h20, 32'h0, mrd, mer, known);
    txn("abort_readback", 1'b0, 32'h20, 32'h0, rd, er);
    chk("abort_readback rdata", rd, mrd);
    chk("abort_readback err", 32'(er), 32'd0);

    // WAIT_CYCLES=0 instance: valid held high across four requests.
    b_we[0] = 1; b_addr[0] = 32'h0;   b_wd[0] = 32'hCAFE_F00D; b_exp[0] = 32'h0;
    b_we[1] = 1; b_addr[1] = 32'hFFC; b_wd[1] = 32'h0BAD_BEEF; b_exp[1] = 32'h0;
    b_we[2] = 0; b_addr[2] = 32'h0;   b_wd[2] = 32'h0;         b_exp[2] = 32'hCAFE_F00D;
    b_we[3] = 0; b_addr[3] = 32'hFFC; b_wd[3] = 32'h0;         b_exp[3] = 32'h0BAD_BEEF;
    bus0.req_valid = 1'b1; bus0.req_we = b_we[0]; bus0.req_addr = b_addr[0]; bus0.req_wdata = b_wd[0];
    na = 0; nr = 0; pend = 0; last_rsp = 0;
    for (int i = 0; i < 60 && nr < 4; i++) begin
      @(negedge clk);
      if (pend) begin
        pend = 0;
        if (na < 4) begin
          bus0.req_we = b_we[na]; bus0.req_addr = b_addr[na]; bus0.req_wdata = b_wd[na];
        end else begin
          bus0.req_valid = 1'b0;
        end
      end
      if (bus0.rsp_valid && nr < na) begin
        chk($sformatf("b2b%0d latency", nr), 32'(i - acc_cyc[nr]), 32'd2);
        chk($sformatf("b2b%0d ready_in_resp", nr), 32'(bus0.req_ready), 32'd0);
        chk($sformatf("b2b%0d rdata", nr), bus0.rsp_rdata, b_exp[nr]);
        chk($sformatf("b2b%0d err", nr), 32'(bus0.rsp_err), 32'd0);
        $display("txn b2b%0d we=%0d addr=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
                 nr, b_we[nr], b_addr[nr], bus0.rsp_rdata, bus0.rsp_err, i - acc_cyc[nr]);
        last_rsp = i;
        nr++;
      end
      if (bus0.req_valid && bus0.req_ready && na < 4) begin
        if (na > 0) chk($sformatf("b2b%0d accept_gap", na), 32'(i - last_rsp), 32'd1);
        acc_cyc[na] = i;
        na++;
        pend = 1;
      end
    end
    bus0.req_valid = 1'b0;
    chk("b2b responses", 32'(nr), 32'd4);

    // Random traffic against the model.
    for (int t = 0; t < 60; t++) begin
      logic        we;
      logic [31:0] addr, wd;
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      if ($urandom_range(0, 7) == 0)
        addr = 32'h1000 + ($urandom & 32'h7FFF_EFFF);
      else if ($urandom_range(0, 7) == 0)
        addr = 32'hFFC;
      else
        addr = 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
      model(we, addr, wd, mrd, mer, known);
      txn($sformatf("rnd%0d", t), we, addr, wd, rd, er);
      chk($sformatf("rnd%0d err", t), 32'(er), 32'(mer));
      if (known) chk($sformatf("rnd%0d rdata", t), rd, mrd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
